// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file (SR, Cause, EPC, PrID) with interrupt/exception arbitration.
// Sits in the M stage; Req flushes the pipeline and redirects fetch to the handler.
module cp0_regfile #(
  parameter logic [31:0] PRID = 32'h0000_4A38
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        EXLClr,
  input  logic [31:0] VPC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic [5:0]  HWInt,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] SR_ADDR    = 5'd12;
  localparam logic [4:0] CAUSE_ADDR = 5'd13;
  localparam logic [4:0] EPC_ADDR   = 5'd14;
  localparam logic [4:0] PRID_ADDR  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCode != 5'd0) & ~exl_q;
  assign Req     = int_req | exc_req;

  // A delay-slot victim restarts at its branch so the branch is re-executed.
  assign victim_pc = BD ? (VPC - 32'd4) : VPC;

  assign sr_word    = {16'h0, im_q, 8'h0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'h0, ip_q, 3'b000, exc_code_q, 2'b00};
  assign EPCOut     = epc_q;

  always_comb begin
    DOut = 32'h0;
    case (A1)
      SR_ADDR:    DOut = sr_word;
      CAUSE_ADDR: DOut = cause_word;
      EPC_ADDR:   DOut = epc_q;
      PRID_ADDR:  DOut = PRID;
      default:    DOut = 32'h0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (Req) begin
      // The victim instruction does not commit, so its MTC0/ERET effects are dropped.
      exl_d      = 1'b1;
      bd_d       = BD;
      exc_code_d = int_req ? 5'd0 : ExcCode;
      epc_d      = victim_pc & 32'hFFFF_FFFC;
    end else begin
      if (WE) begin
        case (A2)
          SR_ADDR: begin
            im_d  = DIn[15:10];
            exl_d = DIn[1];
            ie_d  = DIn[0];
          end
          EPC_ADDR: epc_d = DIn & 32'hFFFF_FFFC;
          default:  ;
        endcase
      end
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im_q       <= 6'h0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'h0;
      exc_code_q <= 5'h0;
      epc_q      <= 32'h0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - self-checking bench for cp0_regfile.
// Word-level reference model plus directed literal checks and random stimulus.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  A1, A2, ExcCode;
  logic [31:0] DIn, VPC;
  logic        WE, EXLClr, BD;
  logic [5:0]  HWInt;
  logic [31:0] DOut, EPCOut;
  logic        Req;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model holds each register as the word software would read.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_regfile dut (
    .clk(clk), .reset_n(reset_n), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .EXLClr(EXLClr), .VPC(VPC), .BD(BD), .ExcCode(ExcCode), .HWInt(HWInt),
    .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_int_req();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int_req() || ((ExcCode != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4A38;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
    end else if (m_req()) begin
      m_cause = (32'(BD) << 31) | (32'(HWInt) << 10) | (32'(m_int_req() ? 5'd0 : ExcCode) << 2);
      m_epc   = (BD ? VPC - 32'd4 : VPC) & ~32'd3;
      m_sr    = m_sr | 32'h2;
    end else begin
      if (WE && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
      if (WE && A2 == 5'd14) m_epc = DIn & ~32'd3;
      if (EXLClr) m_sr = m_sr & ~32'h2;
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", DOut, m_read(A1));
      check("req", 32'(Req), 32'(m_req()));
      check("epcout", EPCOut, m_epc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    A1 = a;
    #1;
    check(name, DOut, exp);
  endtask

  initial begin
    reset_n = 1'b0; A1 = 0; A2 = 0; DIn = 0; WE = 0; EXLClr = 0;
    VPC = 0; BD = 0; ExcCode = 0; HWInt = 0;
    cyc(); cyc();
    reset_n = 1'b1;
    chk_en = 1'b1;
    cyc();
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("prid", 5'd15, 32'h0000_4A38);
    rd("other", 5'd3, 32'h0);
    check("rst_req", 32'(Req), 32'h0);

    WE = 1; A2 = 5'd12; DIn = 32'hFFFF_FFFF;
    A1 = 5'd12; #1;
    check("sr_no_bypass", DOut, 32'h0);
    cyc();
    WE = 0;
    rd("sr_mask", 5'd12, 32'h0000_FC03);
    WE = 1; A2 = 5'd13;
    cyc();
    WE = 0;
    rd("cause_ro", 5'd13, 32'h0);

    WE = 1; A2 = 5'd12; DIn = 32'h0000_0401;
    cyc();
    WE = 0; HWInt = 6'b000001; VPC = 32'h0000_3010; BD = 0;
    #1;
    check("int_req", 32'(Req), 32'h1);
    cyc();
    rd("int_epc", 5'd14, 32'h0000_3010);
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr_exl", 5'd12, 32'h0000_0403);
    check("int_req_drop", 32'(Req), 32'h0);

    HWInt = 0; EXLClr = 1;
    cyc();
    EXLClr = 0; ExcCode = 5'd12; VPC = 32'h0000_3024; BD = 1;
    WE = 1; A2 = 5'd14; DIn = 32'hDEAD_0000;
    #1;
    check("exc_req", 32'(Req), 32'h1);
    cyc();
    WE = 0; ExcCode = 0; BD = 0;
    rd("exc_epc", 5'd14, 32'h0000_3020);
    rd("exc_cause", 5'd13, 32'h8000_0030);

    EXLClr = 1;
    cyc();
    EXLClr = 0; HWInt = 6'b000001; ExcCode = 5'd10; VPC = 32'h0000_3040;
    #1;
    check("prio_req", 32'(Req), 32'h1);
    cyc();
    ExcCode = 0;
    rd("prio_cause", 5'd13, 32'h0000_0400);
    EXLClr = 1;
    #1;
    check("exl_masks", 32'(Req), 32'h0);
    cyc();
    EXLClr = 0;
    rd("eret_sr", 5'd12, 32'h0000_0401);
    check("rearm_req", 32'(Req), 32'h1);
    cyc();
    #2;
    reset_n = 1'b0;
    rd("async_sr", 5'd12, 32'h0);
    rd("async_cause", 5'd13, 32'h0);
    rd("async_epc", 5'd14, 32'h0);
    check("async_req", 32'(Req), 32'h0);
    HWInt = 0;
    cyc();
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      A1      = 5'(10 + $urandom_range(0, 7));
      A2      = 5'(($urandom_range(0, 3) == 0) ? 5'd3 : 5'(12 + $urandom_range(0, 3)));
      WE      = ($urandom_range(0, 3) == 0);
      DIn     = $urandom;
      if ($urandom_range(0, 1) == 0) DIn[1] = 1'b0;
      EXLClr  = ($urandom_range(0, 5) == 0);
      VPC     = $urandom;
      BD      = $urandom_range(0, 1) == 1;
      ExcCode = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      HWInt   = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      if (i % 500 == 250) begin
        #3;
        reset_n = 1'b0;
        #1;
        check("rnd_async_sr", DOut & ((A1 == 5'd15) ? 32'h0 : 32'hFFFF_FFFF), 32'h0);
        cyc();
        reset_n = 1'b1;
      end else begin
        cyc();
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
